// File: rtl/rtc_time_counter_if.sv
// Purpose : groups the load request, run control and running-time outputs of the RTC counter.
// Latency : n/a (signal bundle only).
// Backpressure: none; master drives load/run_enable, slave drives time and pulse outputs.
//
// Ports (slave view):
//   load, load_time[23:0], run_enable           -> into the counter
//   current_time[23:0], sec_tick, midnight,
//   load_err, blink_phase                       <- out of the counter
interface rtc_time_counter_if;
    logic        load;
    logic [23:0] load_time;
    logic        run_enable;
    logic [23:0] current_time;
    logic        sec_tick;
    logic        midnight;
    logic        load_err;
    logic        blink_phase;

    modport master (
        output load, load_time, run_enable,
        input  current_time, sec_tick, midnight, load_err, blink_phase
    );

    modport slave (
        input  load, load_time, run_enable,
        output current_time, sec_tick, midnight, load_err, blink_phase
    );
endinterface

// File: rtl/rtc_time_counter.sv
// Purpose : BCD time-of-day counter (HH:MM:SS, 24 h) with load, pause and blink phase.
// Latency : load visible 1 cycle after the sampling edge; sec_tick every TICKS_PER_SEC cycles.
// Backpressure: none; all outputs are registered single-cycle pulses or levels.
//
// Ports:
//   clk          board clock (single domain)
//   rst_n        asynchronous active-low reset
//   bus.load / bus.load_time    level load request and BCD time to load
//   bus.run_enable              1 = advance, 0 = freeze time and prescaler
//   bus.current_time            running BCD time
//   bus.sec_tick / bus.midnight one-cycle pulses on advance / 23:59:59 wrap
//   bus.load_err                one-cycle pulse on rising load with invalid BCD
//   bus.blink_phase             free-running square wave for digit flashing
module rtc_time_counter #(
    parameter int TICKS_PER_SEC  = 50_000_000,
    parameter int TICKS_PER_HALF = 25_000_000
) (
    input  logic               clk,
    input  logic               rst_n,
    rtc_time_counter_if.slave  bus
);

    localparam int PW = (TICKS_PER_SEC  > 1) ? $clog2(TICKS_PER_SEC)  : 1;
    localparam int HW = (TICKS_PER_HALF > 1) ? $clog2(TICKS_PER_HALF) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
    localparam logic [HW-1:0] HALF_LAST  = HW'(TICKS_PER_HALF - 1);

    logic [23:0]   time_q,  time_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [HW-1:0] half_q,  half_d;
    logic          blink_q, blink_d;
    logic          tick_q,  tick_d;
    logic          mid_q,   mid_d;
    logic          err_q,   err_d;
    logic          load_prev_q;
    logic          load_ok;

    // Advance a valid BCD time by one second with full carry and 24 h wrap.
    function automatic logic [23:0] bcd_inc(input logic [23:0] t);
        logic [3:0] hl, hr, ml, mr, sl, sr;
        {hl, hr, ml, mr, sl, sr} = t;
        if (sr != 4'd9) begin
            sr = sr + 4'd1;
        end else begin
            sr = 4'd0;
            if (sl != 4'd5) begin
                sl = sl + 4'd1;
            end else begin
                sl = 4'd0;
                if (mr != 4'd9) begin
                    mr = mr + 4'd1;
                end else begin
                    mr = 4'd0;
                    if (ml != 4'd5) begin
                        ml = ml + 4'd1;
                    end else begin
                        ml = 4'd0;
                        if (hl == 4'd2 && hr == 4'd3) begin
                            hl = 4'd0;
                            hr = 4'd0;
                        end else if (hr == 4'd9) begin
                            hr = 4'd0;
                            hl = hl + 4'd1;
                        end else begin
                            hr = hr + 4'd1;
                        end
                    end
                end
            end
        end
        return {hl, hr, ml, mr, sl, sr};
    endfunction

    // BCD range check: digits <= 9, tens of min/sec <= 5, hours <= 23.
    always_comb begin
        load_ok = (bus.load_time[23:20] <= 4'd2) &&
                  (bus.load_time[19:16] <= 4'd9) &&
                  (bus.load_time[15:12] <= 4'd5) &&
                  (bus.load_time[11:8]  <= 4'd9) &&
                  (bus.load_time[7:4]   <= 4'd5) &&
                  (bus.load_time[3:0]   <= 4'd9) &&
                  !((bus.load_time[23:20] == 4'd2) && (bus.load_time[19:16] > 4'd3));
    end

    always_comb begin
        time_d  = time_q;
        presc_d = presc_q;
        tick_d  = 1'b0;
        mid_d   = 1'b0;
        err_d   = 1'b0;
        half_d  = half_q;
        blink_d = blink_q;

        // Any load level blocks counting; an invalid one just freezes state.
        if (bus.load) begin
            if (load_ok) begin
                time_d  = bus.load_time;
                presc_d = '0;
            end else if (!load_prev_q) begin
                err_d = 1'b1;
            end
        end else if (bus.run_enable) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                time_d  = bcd_inc(time_q);
                tick_d  = 1'b1;
                mid_d   = (time_q == 24'h235959);
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end

        // Blink runs regardless of load and run_enable.
        if (half_q == HALF_LAST) begin
            half_d  = '0;
            blink_d = ~blink_q;
        end else begin
            half_d = half_q + HW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            time_q      <= 24'h000000;
            presc_q     <= '0;
            half_q      <= '0;
            blink_q     <= 1'b0;
            tick_q      <= 1'b0;
            mid_q       <= 1'b0;
            err_q       <= 1'b0;
            load_prev_q <= 1'b0;
        end else begin
            time_q      <= time_d;
            presc_q     <= presc_d;
            half_q      <= half_d;
            blink_q     <= blink_d;
            tick_q      <= tick_d;
            mid_q       <= mid_d;
            err_q       <= err_d;
            load_prev_q <= bus.load;
        end
    end

    assign bus.current_time = time_q;
    assign bus.sec_tick     = tick_q;
    assign bus.midnight     = mid_q;
    assign bus.load_err     = err_q;
    assign bus.blink_phase  = blink_q;

endmodule

// File: tb/tb_rtc_time_counter.sv
// Purpose : directed self-checking bench for rtc_time_counter (TICKS_PER_SEC=10, TICKS_PER_HALF=5).
// Latency : inputs change 1 ns after a rising edge; outputs sampled at the same point.
// Backpressure: none.
module tb_rtc_time_counter;

    logic clk;
    logic rst_n;
    int   total;
    int   fails;

    rtc_time_counter_if bus();

    rtc_time_counter #(
        .TICKS_PER_SEC (10),
        .TICKS_PER_HALF(5)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [23:0] carry_in  [3] = '{24'h095959, 24'h195959, 24'h005909};
    logic [23:0] carry_exp [3] = '{24'h100000, 24'h200000, 24'h005910};
    logic [23:0] bad_time  [3] = '{24'h245000, 24'h106000, 24'h0A0000};

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_pulse(input logic [23:0] v);
        bus.load      = 1'b1;
        bus.load_time = v;
        step(1);
        bus.load      = 1'b0;
    endtask

    task automatic chk24(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        int  cnt;
        int  toggles;
        int  ticks;
        logic prev_blink;

        total          = 0;
        fails          = 0;
        rst_n          = 1'b0;
        bus.load       = 1'b0;
        bus.load_time  = 24'h000000;
        bus.run_enable = 1'b0;

        // Power-on reset values.
        step(2);
        chk24("rst_time",     bus.current_time, 24'h000000);
        chk1 ("rst_tick",     bus.sec_tick,     1'b0);
        chk1 ("rst_midnight", bus.midnight,     1'b0);
        chk1 ("rst_err",      bus.load_err,     1'b0);
        chk1 ("rst_blink",    bus.blink_phase,  1'b0);

        // Async reset mid-second with a non-zero time.
        rst_n          = 1'b1;
        bus.run_enable = 1'b1;
        load_pulse(24'h123456);
        chk24("load_123456", bus.current_time, 24'h123456);
        step(3);
        rst_n = 1'b0;
        #2;
        chk24("async_rst_time",  bus.current_time, 24'h000000);
        chk1 ("async_rst_tick",  bus.sec_tick,     1'b0);
        chk1 ("async_rst_blink", bus.blink_phase,  1'b0);
        step(2);
        rst_n = 1'b1;
        step(4);
        chk1("blink_before_5", bus.blink_phase, 1'b0);
        step(1);
        chk1("blink_at_5",     bus.blink_phase, 1'b1);
        step(4);
        chk1("no_tick_at_9",   bus.sec_tick,    1'b0);
        step(1);
        chk1 ("blink_at_10",   bus.blink_phase, 1'b0);
        chk1 ("tick_at_10",    bus.sec_tick,    1'b1);
        chk24("time_at_10",    bus.current_time, 24'h000001);

        // Midnight wrap.
        load_pulse(24'h235958);
        chk24("mid_load",     bus.current_time, 24'h235958);
        chk1 ("mid_load_tick", bus.sec_tick,    1'b0);
        step(9);
        chk1 ("mid_no_tick9", bus.sec_tick,     1'b0);
        step(1);
        chk24("mid_235959",   bus.current_time, 24'h235959);
        chk1 ("mid_tick1",    bus.sec_tick,     1'b1);
        chk1 ("mid_not_yet",  bus.midnight,     1'b0);
        step(1);
        chk1 ("mid_tick_drop", bus.sec_tick,    1'b0);
        step(8);
        chk1 ("mid_no_tick19", bus.sec_tick,    1'b0);
        step(1);
        chk24("mid_000000",   bus.current_time, 24'h000000);
        chk1 ("mid_tick2",    bus.sec_tick,     1'b1);
        chk1 ("mid_pulse",    bus.midnight,     1'b1);
        step(1);
        chk1 ("mid_pulse_drop", bus.midnight,   1'b0);

        // Carry chain.
        for (int i = 0; i < 3; i++) begin
            load_pulse(carry_in[i]);
            step(10);
            chk24("carry_time", bus.current_time, carry_exp[i]);
            chk1 ("carry_tick", bus.sec_tick,     1'b1);
        end

        // Invalid loads while frozen at 10:10:10.
        bus.run_enable = 1'b0;
        load_pulse(24'h101010);
        chk24("valid_load", bus.current_time, 24'h101010);
        chk1 ("valid_no_err", bus.load_err,   1'b0);
        step(2);
        for (int i = 0; i < 3; i++) begin
            cnt           = 0;
            bus.load      = 1'b1;
            bus.load_time = bad_time[i];
            for (int c = 0; c < 4; c++) begin
                step(1);
                if (bus.load_err) cnt++;
            end
            bus.load = 1'b0;
            step(1);
            if (bus.load_err) cnt++;
            chkn ("bad_err_count", cnt, 1);
            chk24("bad_time_held", bus.current_time, 24'h101010);
            step(1);
        end

        // Pause after 4 prescaler counts, resume continues the partial second.
        bus.run_enable = 1'b1;
        load_pulse(24'h101010);
        step(4);
        bus.run_enable = 1'b0;
        ticks      = 0;
        toggles    = 0;
        prev_blink = bus.blink_phase;
        for (int c = 0; c < 20; c++) begin
            step(1);
            if (bus.sec_tick) ticks++;
            if (bus.blink_phase !== prev_blink) toggles++;
            prev_blink = bus.blink_phase;
        end
        chkn ("pause_ticks",   ticks,   0);
        chkn ("pause_toggles", toggles, 4);
        chk24("pause_time",    bus.current_time, 24'h101010);
        bus.run_enable = 1'b1;
        step(5);
        chk1 ("resume_no_tick5", bus.sec_tick, 1'b0);
        step(1);
        chk1 ("resume_tick6",    bus.sec_tick, 1'b1);
        chk24("resume_time",     bus.current_time, 24'h101011);

        // Load in the prescaler terminal cycle wins over the tick.
        step(9);
        bus.load      = 1'b1;
        bus.load_time = 24'h080000;
        step(1);
        bus.load      = 1'b0;
        chk24("coll_time",     bus.current_time, 24'h080000);
        chk1 ("coll_no_tick",  bus.sec_tick,     1'b0);
        chk1 ("coll_no_mid",   bus.midnight,     1'b0);
        step(9);
        chk1 ("coll_no_tick9", bus.sec_tick,     1'b0);
        step(1);
        chk1 ("coll_tick10",   bus.sec_tick,     1'b1);
        chk24("coll_time_inc", bus.current_time, 24'h080001);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule

// File: doc/rtc_time_counter.md
# rtc_time_counter

Running time-of-day counter for the alarm clock. Sits directly downstream of the time-setting stage: it loads the user-confirmed BCD time, then advances it once per second from the 50 MHz board clock with full BCD carry and 24-hour wrap. It also provides the free-running blink phase that the display path uses to flash the digit being edited.

## Interface

- `TICKS_PER_SEC`, default 50_000_000: `clk` cycles per second; the bench overrides it to 10.
- `TICKS_PER_HALF`, default 25_000_000: `clk` cycles per `blink_phase` half-period; the bench overrides it to 5.
- `clk`, input, 1 bit: the 50 MHz board clock. Single clock domain.
- `rst_n`, input, 1 bit: reset, asynchronous, active-low.
- `load`, input, 1 bit: level-sensitive load request, driven by the debounced confirm switch.
- `load_time`, input, 24 bits: BCD {hour_left, hour_right, min_left, min_right, sec_left, sec_right}, 4 bits per digit, MSB first.
- `run_enable`, input, 1 bit: 1 = time advances; 0 = time and prescaler frozen (set mode).
- `current_time`, output, 24 bits: running time, same BCD format as `load_time`.
- `sec_tick`, output, 1 bit: one-cycle pulse in the cycle `current_time` shows a newly advanced value.
- `midnight`, output, 1 bit: one-cycle pulse coincident with `sec_tick` when the time wraps 23:59:59 -> 00:00:00.
- `load_err`, output, 1 bit: one-cycle pulse when a load is rejected as invalid BCD.
- `blink_phase`, output, 1 bit: square wave, toggles every `TICKS_PER_HALF` cycles.

## Operation

- **Reset (`rst_n` = 0, async):**
  - `current_time` = 24'h000000.
  - Prescaler and half-period counter = 0.
  - `sec_tick`, `midnight`, `load_err`, `blink_phase` = 0.
  - Reset asserted mid-second discards the partial second.
- **Validity check on `load_time`:**
  - Every digit must be ≤ 9.
  - min_left and sec_left must be ≤ 5.
  - Hours: hour_left ≤ 2; if hour_left = 2, hour_right must be ≤ 3.
- **Load, valid (each cycle `load` = 1):**
  - `current_time` <= `load_time`.
  - Prescaler <= 0.
  - No `sec_tick` that cycle.
  - While `load` stays high, the counter keeps reloading and does not advance.
- **Load, invalid:**
  - `current_time` and prescaler unchanged.
  - `load_err` pulses once, on the rising edge of `load` only.
- **Priority:** reset > load > tick.
- **Counting (`run_enable` = 1, `load` = 0):**
  - Prescaler counts 0 .. `TICKS_PER_SEC`-1.
  - At terminal count: prescaler <= 0, time increments by one second, `sec_tick` = 1 for the next cycle.
- **BCD carry chain:**
  - sec_right 9->0 carries into sec_left.
  - sec_left 5->0 carries into min_right.
  - min_right 9->0 carries into min_left.
  - min_left 5->0 carries into hours.
  - Hours: hour_right 9->0 carries into hour_left, except 23 -> 00, which also pulses `midnight`.
- **Pause (`run_enable` = 0):** prescaler holds its value. Resuming continues the partial second; it does not restart it.
- **`blink_phase`:** its own counter, independent of `run_enable` and `load`. Keeps toggling during set mode.

## Timing

- All outputs are registered. No combinational path from input to output.
- **Load latency:** `current_time` reflects `load_time` 1 cycle after the edge that samples `load` = 1.
- **First tick after load:** if `load` falls so the last reload happens at edge k, the first `sec_tick` is visible after edge k + `TICKS_PER_SEC`.
- **Tick period:** consecutive `sec_tick` pulses are exactly `TICKS_PER_SEC` cycles apart while running.
- `sec_tick`, `midnight` and the new `current_time` appear in the same cycle. `midnight` is never asserted without `sec_tick`.
- **Load coinciding with terminal count:** the load wins; no tick, no increment, no `midnight`.
- `blink_phase` first toggles `TICKS_PER_HALF` cycles after reset release.

## Test plan

All scenarios use `TICKS_PER_SEC` = 10 and `TICKS_PER_HALF` = 5.

1. **Reset:** assert `rst_n` = 0 mid-count with `current_time` = 24'h123456 -> all outputs 0 immediately (async). After release, `blink_phase` toggles every 5 cycles.
2. **Midnight wrap:** load 24'h235958, one-cycle `load`, `run_enable` = 1 -> after 10 cycles 24'h235959 with `sec_tick`. After 10 more, 24'h000000 with `sec_tick` and `midnight` both = 1 for one cycle.
3. **Carry chain:**
   - Load 24'h095959 -> next tick gives 24'h100000.
   - Load 24'h195959 -> next tick gives 24'h200000.
   - Load 24'h005909 -> next tick gives 24'h005910.
4. **Invalid load:** with time 24'h101010, hold `load` high with 24'h245000, then 24'h106000, then 24'h0A0000 -> time unchanged. Exactly one `load_err` pulse per rising edge of `load`.
5. **Pause/resume:** `run_enable` = 0 after 4 prescaler counts for 20 cycles -> no `sec_tick`, time frozen, `blink_phase` still toggling. On resume, `sec_tick` fires 6 cycles later.
6. **Load/tick collision:** assert `load` (24'h080000) in the prescaler-terminal cycle -> `current_time` = 24'h080000, no `sec_tick`. Next tick exactly 10 cycles after `load` falls.
